butterfly_r2_pipe: RTL

Pipelined, parametrised radix-2 DIT butterfly for the FFT datapath. It computes out0 = in0 + W·in1 and out1 = in0 − W·in1 in signed Qm.Q fixed point at one butterfly per clock. It adds a valid/ready handshake with backpressure, per-sample forward/inverse (conjugate twiddle) mode, optional per-stage ÷2 scaling, rounding, saturation and a sticky overflow flag. It replaces the clock-divided, multi-cycle butterfly in the FFT stage array.

---
 rtl/butterfly_r2_pipe.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/butterfly_r2_pipe.sv
// Four-stage pipelined radix-2 DIT butterfly: out0 = in0 + W*in1, out1 = in0 - W*in1 in signed Q fixed point,
// with valid/ready backpressure, per-sample conjugate twiddle, optional /2 scaling, saturation and sticky overflow.
module butterfly_r2_pipe #(
    parameter int N = 16,
    parameter int Q = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic signed [N-1:0] i_in0_re,
    input  logic signed [N-1:0] i_in0_im,
    input  logic signed [N-1:0] i_in1_re,
    input  logic signed [N-1:0] i_in1_im,
    input  logic signed [N-1:0] i_twiddle_re,
    input  logic signed [N-1:0] i_twiddle_im,
    input  logic                i_inverse,
    input  logic                i_scale,
    output logic                o_valid,
    input  logic                i_ready,
    output logic signed [N-1:0] o_out0_re,
    output logic signed [N-1:0] o_out0_im,
    output logic signed [N-1:0] o_out1_re,
    output logic signed [N-1:0] o_out1_im,
    output logic                o_ovf,
    input  logic                i_ovf_clr
);

    localparam logic signed [2*N:0] MAXW = {{(N+2){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [2*N:0] MINW = {{(N+2){1'b1}}, {(N-1){1'b0}}};
    localparam logic signed [2*N:0] RND  = {{(2*N){1'b0}}, 1'b1} << (Q-1);
    localparam logic signed [N-1:0] MAXN = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] MINN = {1'b1, {(N-1){1'b0}}};

    function automatic logic signed [N-1:0] neg_sat(input logic signed [N-1:0] x);
        return (x == MINN) ? MAXN : -x;
    endfunction

    function automatic logic signed [2*N-1:0] mul(input logic signed [N-1:0] a,
                                                  input logic signed [N-1:0] b);
        logic signed [2*N-1:0] ae;
        logic signed [2*N-1:0] be;
        ae = (2*N)'(a);
        be = (2*N)'(b);
        return ae * be;
    endfunction

    function automatic logic signed [2*N:0] rnd_shr(input logic signed [2*N:0] x);
        logic signed [2*N:0] r;
        r = x + RND;
        return r >>> Q;
    endfunction

    function automatic logic is_sat(input logic signed [2*N:0] x);
        return (x > MAXW) || (x < MINW);
    endfunction

    function automatic logic signed [N-1:0] sat(input logic signed [2*N:0] x);
        logic signed [N-1:0] r;
        if (x > MAXW)      r = MAXN;
        else if (x < MINW) r = MINN;
        else               r = x[N-1:0];
        return r;
    endfunction

    // (s + 1) >>> 1 of an N+1 bit sum always lands inside the N-bit range
    function automatic logic signed [N-1:0] half(input logic signed [N:0] s);
        logic signed [N:0] h;
        h = (s + (N+1)'(1)) >>> 1;
        return h[N-1:0];
    endfunction

    function automatic logic signed [N-1:0] s4_out(input logic signed [N:0] s, input logic scl);
        return scl ? half(s) : sat((2*N+1)'(s));
    endfunction

    function automatic logic s4_sat(input logic signed [N:0] s, input logic scl);
        return !scl && is_sat((2*N+1)'(s));
    endfunction

    logic                  en;
    logic                  vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q;
    logic                  scl_p1_q, scl_p2_q, scl_p3_q;
    logic signed [N-1:0]   in0_re_p1_q, in0_im_p1_q, in1_re_p1_q, in1_im_p1_q;
    logic signed [N-1:0]   tw_re_p1_q, tw_im_p1_q, tw_im_p1_d;
    logic signed [N-1:0]   in0_re_p2_q, in0_im_p2_q;
    logic signed [2*N-1:0] prd0_p2_q, prd1_p2_q, prd2_p2_q, prd3_p2_q;
    logic signed [2*N-1:0] prd0_p2_d, prd1_p2_d, prd2_p2_d, prd3_p2_d;
    logic signed [2*N:0]   tr_w, ti_w;
    logic signed [N-1:0]   in0_re_p3_q, in0_im_p3_q;
    logic signed [N-1:0]   t_re_p3_q, t_im_p3_q, t_re_p3_d, t_im_p3_d;
    logic signed [N:0]     s0_re, s0_im, s1_re, s1_im;
    logic signed [N-1:0]   out0_re_q, out0_im_q, out1_re_q, out1_im_q;
    logic signed [N-1:0]   out0_re_d, out0_im_d, out1_re_d, out1_im_d;
    logic                  ovf3, ovf4, ovf_q, ovf_d;

    assign en      = !vld_p4_q || i_ready;
    assign o_ready = en && i_rst;

    // Stage 1: operand capture, twiddle conjugated for inverse transforms
    always_comb begin
        tw_im_p1_d = i_inverse ? neg_sat(i_twiddle_im) : i_twiddle_im;
    end

    always_ff @(posedge i_clk) begin
        if (en) begin
            in0_re_p1_q <= i_in0_re;
            in0_im_p1_q <= i_in0_im;
            in1_re_p1_q <= i_in1_re;
            in1_im_p1_q <= i_in1_im;
            tw_re_p1_q  <= i_twiddle_re;
            tw_im_p1_q  <= tw_im_p1_d;
            scl_p1_q    <= i_scale;
        end
    end

    // Stage 2: four full-width partial products
    always_comb begin
        prd0_p2_d = mul(in1_re_p1_q, tw_re_p1_q);
        prd1_p2_d = mul(in1_im_p1_q, tw_im_p1_q);
        prd2_p2_d = mul(in1_re_p1_q, tw_im_p1_q);
        prd3_p2_d = mul(in1_im_p1_q, tw_re_p1_q);
    end

    always_ff @(posedge i_clk) begin
        if (en) begin
            prd0_p2_q   <= prd0_p2_d;
            prd1_p2_q   <= prd1_p2_d;
            prd2_p2_q   <= prd2_p2_d;
            prd3_p2_q   <= prd3_p2_d;
            in0_re_p2_q <= in0_re_p1_q;
            in0_im_p2_q <= in0_im_p1_q;
            scl_p2_q    <= scl_p1_q;
        end
    end

    // Stage 3: complex product W*in1, rounded back to Q and saturated
    always_comb begin
        tr_w      = rnd_shr((2*N+1)'(prd0_p2_q) - (2*N+1)'(prd1_p2_q));
        ti_w      = rnd_shr((2*N+1)'(prd2_p2_q) + (2*N+1)'(prd3_p2_q));
        t_re_p3_d = sat(tr_w);
        t_im_p3_d = sat(ti_w);
        ovf3      = vld_p2_q && (is_sat(tr_w) || is_sat(ti_w));
    end

    always_ff @(posedge i_clk) begin
        if (en) begin
            t_re_p3_q   <= t_re_p3_d;
            t_im_p3_q   <= t_im_p3_d;
            in0_re_p3_q <= in0_re_p2_q;
            in0_im_p3_q <= in0_im_p2_q;
            scl_p3_q    <= scl_p2_q;
        end
    end

    // Stage 4: sum/difference with optional halving, then the output register
    always_comb begin
        s0_re     = (N+1)'(in0_re_p3_q) + (N+1)'(t_re_p3_q);
        s0_im     = (N+1)'(in0_im_p3_q) + (N+1)'(t_im_p3_q);
        s1_re     = (N+1)'(in0_re_p3_q) - (N+1)'(t_re_p3_q);
        s1_im     = (N+1)'(in0_im_p3_q) - (N+1)'(t_im_p3_q);
        out0_re_d = s4_out(s0_re, scl_p3_q);
        out0_im_d = s4_out(s0_im, scl_p3_q);
        out1_re_d = s4_out(s1_re, scl_p3_q);
        out1_im_d = s4_out(s1_im, scl_p3_q);
        ovf4      = vld_p3_q && (s4_sat(s0_re, scl_p3_q) || s4_sat(s0_im, scl_p3_q) ||
                                 s4_sat(s1_re, scl_p3_q) || s4_sat(s1_im, scl_p3_q));
        ovf_d     = (ovf_q && !i_ovf_clr) || (en && (ovf3 || ovf4));
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            vld_p3_q  <= 1'b0;
            vld_p4_q  <= 1'b0;
            ovf_q     <= 1'b0;
            out0_re_q <= '0;
            out0_im_q <= '0;
            out1_re_q <= '0;
            out1_im_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            if (en) begin
                vld_p1_q  <= i_valid;
                vld_p2_q  <= vld_p1_q;
                vld_p3_q  <= vld_p2_q;
                vld_p4_q  <= vld_p3_q;
                out0_re_q <= out0_re_d;
                out0_im_q <= out0_im_d;
                out1_re_q <= out1_re_d;
                out1_im_q <= out1_im_d;
            end
        end
    end

    assign o_valid   = vld_p4_q;
    assign o_out0_re = out0_re_q;
    assign o_out0_im = out0_im_q;
    assign o_out1_re = out1_re_q;
    assign o_out1_im = out1_im_q;
    assign o_ovf     = ovf_q;

endmodule
